// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Purely declarative: no latency, no backpressure.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic src_match(input logic use_src,
                                       input logic [4:0] src,
                                       input logic [4:0] dst);
        return use_src && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous clear; holds at all-ones instead of wrapping.
// Count visible one cycle after i_inc; never backpressures.
module hazard_stall_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for load-use, taken-branch redirect and data-memory wait hazards.
// Mealy outputs: combinational from registered state plus current inputs; a stuck memory goes fatal.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [4:0]       i_ex_wr,
    input  logic             i_ex_we,
    input  logic             i_ex_is_load,
    input  logic             i_ex_branch_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_pc_stall,
    output logic             o_if_id_stall,
    output logic             o_if_id_flush,
    output logic             o_id_ex_stall,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_stall,
    output logic             o_mem_wb_bubble,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cycles
);

    localparam int              WC_W       = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_LIMIT = WC_W'(MAX_WAIT);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [WC_W-1:0] r_wait_cnt;
    logic [WC_W-1:0] w_wait_cnt_nxt;

    logic w_lu;
    logic w_wait;
    logic w_freeze;

    assign w_lu = i_ex_is_load && i_ex_we && (i_ex_wr != REG_ZERO) &&
                  (src_match(i_id_use_rs1, i_id_rs1, i_ex_wr) ||
                   src_match(i_id_use_rs2, i_id_rs2, i_ex_wr));

    // mem_ready on its own (no request) never matters
    assign w_wait = i_mem_req && !i_mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_wait) begin
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = WC_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (!w_wait) begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WAIT_LIMIT) begin
                    w_state_nxt = ST_TIMEOUT;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WC_W'(1);
                end
            end
            ST_TIMEOUT: begin
                w_state_nxt = ST_TIMEOUT;
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // A held EX branch stays asserted through a freeze and is applied once it lifts
    assign w_freeze = (r_state == ST_TIMEOUT) || w_wait;

    always_comb begin
        o_pc_stall      = 1'b0;
        o_if_id_stall   = 1'b0;
        o_if_id_flush   = 1'b0;
        o_id_ex_stall   = 1'b0;
        o_id_ex_flush   = 1'b0;
        o_ex_mem_stall  = 1'b0;
        o_mem_wb_bubble = 1'b0;
        if (rst_n) begin
            if (w_freeze) begin
                o_pc_stall      = 1'b1;
                o_if_id_stall   = 1'b1;
                o_id_ex_stall   = 1'b1;
                o_ex_mem_stall  = 1'b1;
                o_mem_wb_bubble = 1'b1;
            end else if (i_ex_branch_taken) begin
                o_if_id_flush = 1'b1;
                o_id_ex_flush = 1'b1;
            end else if (w_lu) begin
                o_pc_stall    = 1'b1;
                o_if_id_stall = 1'b1;
                o_id_ex_flush = 1'b1;
            end
        end
    end

    assign o_mem_timeout = (r_state == ST_TIMEOUT);

    hazard_stall_ctrl_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (o_pc_stall),
        .o_cnt (o_stall_cycles)
    );

endmodule
